// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready handshake bundle carrying a control and a data field.
// The master drives valid/ctrl/data and the slave drives ready.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline register between CPU stages.
// Control bits selected by CLR_MASK are cleared on bubbles, flush and kill; data is
// always carried. An empty stage loads even while downstream stalls (bubble collapse).
// Optional feature macro: PIPE_SKID_EN adds one skid entry so up.ready comes from a flop.
// The interface instances must use the same DATA_W/CTRL_W as this module.
module pipe_stage_reg #(
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]  CLR_MASK = {CTRL_W{1'b1}},
    parameter int unsigned        CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                kill,
    pipe_stage_reg_if.slave     up,
    pipe_stage_reg_if.master    dn,
    output logic [CNT_W-1:0]    bubble_count
);

    logic              load;
    logic              dn_valid_q, dn_valid_d;
    logic [CTRL_W-1:0] dn_ctrl_q, dn_ctrl_d;
    logic [DATA_W-1:0] dn_data_q, dn_data_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    // Entry presented to the main register when it loads.
    logic              src_live;
    logic              src_squash;
    logic [CTRL_W-1:0] src_ctrl;
    logic [DATA_W-1:0] src_data;

    assign load = dn.ready | ~dn_valid_q;

    assign dn.valid     = dn_valid_q;
    assign dn.ctrl      = dn_ctrl_q;
    assign dn.data      = dn_data_q;
    assign bubble_count = bubble_cnt_q;

`ifdef PIPE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              up_ready_q, up_ready_d;

    assign up.ready = up_ready_q;

    // Main register drains the skid entry first to keep FIFO order.
    always_comb begin
        if (skid_valid_q) begin
            src_live   = 1'b1;
            src_squash = 1'b0;
            src_ctrl   = skid_ctrl_q;
            src_data   = skid_data_q;
        end else begin
            src_live   = up.valid & ~flush;
            src_squash = ~up.valid | flush;
            src_ctrl   = up.ctrl;
            src_data   = up.data;
        end
    end

    // Skid capture/drain; only a real upstream entry is parked while main is blocked.
    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            if (load) begin
                skid_valid_d = 1'b0;
            end
        end else if (!load && up.valid) begin
            skid_valid_d = ~flush;
            skid_ctrl_d  = flush ? (up.ctrl & ~CLR_MASK) : up.ctrl;
            skid_data_d  = up.data;
        end
        if (kill) begin
            skid_valid_d = 1'b0;
            skid_ctrl_d  = skid_ctrl_d & ~CLR_MASK;
        end
        up_ready_d = ~skid_valid_d;
    end

    // Skid state and registered upstream ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            up_ready_q   <= 1'b1;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            up_ready_q   <= up_ready_d;
        end
    end
`else
    assign up.ready = load;

    // Without skid the main register always loads straight from upstream.
    always_comb begin
        src_live   = up.valid & ~flush;
        src_squash = ~up.valid | flush;
        src_ctrl   = up.ctrl;
        src_data   = up.data;
    end
`endif

    // Main register next state; kill overrides valid and masked control after the load.
    always_comb begin
        dn_valid_d = dn_valid_q;
        dn_ctrl_d  = dn_ctrl_q;
        dn_data_d  = dn_data_q;
        if (load) begin
            dn_valid_d = src_live;
            dn_ctrl_d  = src_squash ? (src_ctrl & ~CLR_MASK) : src_ctrl;
            dn_data_d  = src_data;
        end
        if (kill) begin
            dn_valid_d = 1'b0;
            dn_ctrl_d  = dn_ctrl_d & ~CLR_MASK;
        end
    end

    // Saturating count of bubbles taken by downstream.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (dn.ready && !dn_valid_q && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // Main register and bubble counter state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dn_valid_q   <= 1'b0;
            dn_ctrl_q    <= '0;
            dn_data_q    <= '0;
            bubble_cnt_q <= '0;
        end else begin
            dn_valid_q   <= dn_valid_d;
            dn_ctrl_q    <= dn_ctrl_d;
            dn_data_q    <= dn_data_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vectors for pipe_stage_reg with CLR_MASK = 16'h00FF.
// Covers the PIPE_SKID_EN build as well when the macro is defined.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        kill;
    logic [15:0] bubble_count;

    int n_vec;
    int n_err;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(16)) up_if ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(16)) dn_if ();

    pipe_stage_reg #(
        .DATA_W   (32),
        .CTRL_W   (16),
        .CLR_MASK (16'h00FF),
        .CNT_W    (16)
    ) u_dut (
        .clock        (clk),
        .reset        (rst),
        .flush        (flush),
        .kill         (kill),
        .up           (up_if.slave),
        .dn           (dn_if.master),
        .bubble_count (bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_up(input logic v, input logic [15:0] c, input logic [31:0] d);
        up_if.valid = v;
        up_if.ctrl  = c;
        up_if.data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        flush = 1'b0;
        kill  = 1'b0;
        dn_if.ready = 1'b0;
        drive_up(1'b0, 16'h0, 32'h0);
        #12;
        check_eq("rst_valid", dn_if.valid, 0);
        check_eq("rst_ctrl", dn_if.ctrl, 0);
        check_eq("rst_data", dn_if.data, 0);
        check_eq("rst_count", bubble_count, 0);
        check_eq("rst_up_ready", up_if.ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Stream four entries; the first loads into the empty stage with downstream stalled.
        for (int i = 0; i < 4; i++) begin
            dn_if.ready = (i != 0);
            drive_up(1'b1, 16'h1000 + 16'(i), 32'h100 + 32'(i));
            step();
            check_eq($sformatf("stream_data%0d", i), dn_if.data, 64'h100 + 64'(i));
            check_eq($sformatf("stream_valid%0d", i), dn_if.valid, 1);
            check_eq($sformatf("stream_ctrl%0d", i), dn_if.ctrl, 64'h1000 + 64'(i));
        end
        check_eq("stream_count", bubble_count, 0);

`ifndef PIPE_SKID_EN
        // Downstream stall holds the entry and drops up_ready combinationally.
        dn_if.ready = 1'b0;
        drive_up(1'b1, 16'h2000, 32'h200);
        #1;
        check_eq("stall_up_ready", up_if.ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("stall_data%0d", i), dn_if.data, 64'h103);
            check_eq($sformatf("stall_valid%0d", i), dn_if.valid, 1);
            check_eq($sformatf("stall_up_ready%0d", i), up_if.ready, 0);
        end
        dn_if.ready = 1'b1;
        step();
        check_eq("release_data", dn_if.data, 64'h200);
        check_eq("release_valid", dn_if.valid, 1);
`else
        // A goes to main, B parks in skid as downstream stalls; order must be A, B, C.
        dn_if.ready = 1'b1;
        drive_up(1'b1, 16'h00A0, 32'hA0);
        step();
        check_eq("skid_a_data", dn_if.data, 64'hA0);
        check_eq("skid_a_up_ready", up_if.ready, 1);
        dn_if.ready = 1'b0;
        drive_up(1'b1, 16'h00B0, 32'hB0);
        step();
        check_eq("skid_b_hold", dn_if.data, 64'hA0);
        check_eq("skid_full_up_ready", up_if.ready, 0);
        drive_up(1'b1, 16'h00C0, 32'hC0);
        step();
        check_eq("skid_hold_a", dn_if.data, 64'hA0);
        dn_if.ready = 1'b1;
        step();
        check_eq("skid_b_data", dn_if.data, 64'hB0);
        check_eq("skid_b_ctrl", dn_if.ctrl, 64'h00B0);
        check_eq("skid_drain_up_ready", up_if.ready, 1);
        step();
        check_eq("skid_c_data", dn_if.data, 64'hC0);
        check_eq("skid_c_valid", dn_if.valid, 1);
`endif

        // Flush clears the masked control low byte but still loads data.
        dn_if.ready = 1'b1;
        flush = 1'b1;
        drive_up(1'b1, 16'hABCD, 32'h300);
        step();
        check_eq("flush_ctrl", dn_if.ctrl, 64'hAB00);
        check_eq("flush_valid", dn_if.valid, 0);
        check_eq("flush_data", dn_if.data, 64'h300);
        check_eq("flush_count", bubble_count, 0);
        flush = 1'b0;
        drive_up(1'b0, 16'h1234, 32'h301);
        step();
        check_eq("bubble_count1", bubble_count, 1);
        check_eq("bubble_ctrl", dn_if.ctrl, 64'h1200);
        check_eq("bubble_valid", dn_if.valid, 0);

        // Kill a stalled valid entry: masked control cleared, data kept.
        drive_up(1'b1, 16'hFFFF, 32'h400);
        step();
        check_eq("kill_pre_valid", dn_if.valid, 1);
        check_eq("kill_pre_ctrl", dn_if.ctrl, 64'hFFFF);
        check_eq("kill_pre_count", bubble_count, 2);
        dn_if.ready = 1'b0;
        drive_up(1'b0, 16'h0000, 32'h401);
        step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        check_eq("kill_valid", dn_if.valid, 0);
        check_eq("kill_ctrl", dn_if.ctrl, 64'hFF00);
        check_eq("kill_data", dn_if.data, 64'h400);
        check_eq("kill_count", bubble_count, 2);

        // Kill with flush on an empty stage: loads data, entry squashed.
        kill  = 1'b1;
        flush = 1'b1;
        drive_up(1'b1, 16'h5678, 32'h500);
        step();
        kill  = 1'b0;
        flush = 1'b0;
        check_eq("killflush_valid", dn_if.valid, 0);
        check_eq("killflush_ctrl", dn_if.ctrl, 64'h5600);
        check_eq("killflush_data", dn_if.data, 64'h500);

        // Asynchronous reset in the middle of traffic.
        dn_if.ready = 1'b1;
        drive_up(1'b1, 16'h0F0F, 32'h600);
        step();
        check_eq("pre_rst_valid", dn_if.valid, 1);
        check_eq("pre_rst_count", bubble_count, 3);
`ifdef PIPE_SKID_EN
        dn_if.ready = 1'b0;
        drive_up(1'b1, 16'h0707, 32'h700);
        step();
        check_eq("pre_rst_skid_full", up_if.ready, 0);
`endif
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_valid", dn_if.valid, 0);
        check_eq("async_rst_ctrl", dn_if.ctrl, 0);
        check_eq("async_rst_data", dn_if.data, 0);
        check_eq("async_rst_count", bubble_count, 0);
        check_eq("async_rst_up_ready", up_if.ready, 1);
        @(negedge clk);
        rst = 1'b0;
        dn_if.ready = 1'b1;
        drive_up(1'b0, 16'h0, 32'h0);
        step();
        check_eq("post_rst_valid", dn_if.valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
